// File: rtl/rf_2p_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RF_2P streaming FIFO controller.
package rf_2p_fifo_ctrl_pkg;

  // Words held in the output prefetch buffer.
  localparam int unsigned RF_OB_DEPTH = 2;

  // Pointer increment modulo depth; depth need not be a power of two.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rf_2p_fifo_ctrl_if.sv
// Producer/consumer stream bundle of the RF_2P FIFO controller.
// Signal directions are named from the controller's point of view.
interface rf_2p_fifo_ctrl_if #(
  parameter int unsigned DWD  = 16,
  parameter int unsigned SIZE = 1,
  parameter int unsigned CWD  = 4
);

  logic                  i_clear;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [DWD*SIZE-1:0]   i_in_data;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [DWD*SIZE-1:0]   o_out_data;
  logic [CWD-1:0]        o_count;

  modport slave (
    input  i_clear, i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_data, o_count
  );

  modport master (
    output i_clear, i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_data, o_count
  );

endinterface

// File: rtl/rf_2p_fifo_ctrl_ob_buf.sv
// Two-entry output prefetch buffer: filled from RF read returns, drained by the consumer.
module rf_2p_fifo_ctrl_ob_buf
  import rf_2p_fifo_ctrl_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [RF_OB_DEPTH];
  logic         r_wr_idx;
  logic         r_rd_idx;
  logic [1:0]   r_occ;

  // Storage, indices and occupancy; clear empties the buffer but leaves stale data in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(RF_OB_DEPTH); i++) r_mem[i] <= '0;
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_occ    <= 2'd0;
    end else if (i_clear) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_idx] <= i_data;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (i_pop) r_rd_idx <= ~r_rd_idx;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Head word and occupancy come straight from registers.
  always_comb begin
    o_occ   = r_occ;
    o_valid = (r_occ != 2'd0);
    o_data  = r_mem[r_rd_idx];
  end

endmodule

// File: rtl/rf_2p_fifo_ctrl.sv
// Sequencer that turns one RF_2P register file into a valid/ready streaming FIFO.
// Owns RF pointers and occupancy, hides the 1-cycle read latency behind a 2-entry buffer.
module rf_2p_fifo_ctrl
  import rf_2p_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned DWD   = 16,
  parameter int unsigned SIZE  = 1,
  parameter int unsigned AWD   = $clog2(DEPTH),
  parameter int unsigned CWD   = $clog2(DEPTH + 3)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rf_2p_fifo_ctrl_if.slave    bus,
  output logic                o_rf_read,
  output logic [AWD-1:0]      o_rf_raddr,
  output logic                o_rf_write,
  output logic [AWD-1:0]      o_rf_waddr,
  output logic [DWD*SIZE-1:0] o_rf_wdata,
  input  logic [DWD*SIZE-1:0] i_rf_rdata
);

  localparam int unsigned DW  = DWD * SIZE;
  localparam int unsigned NWD = $clog2(DEPTH + 1);

  logic [AWD-1:0] r_wptr;
  logic [AWD-1:0] r_rptr;
  logic [NWD-1:0] r_rf_cnt;
  logic           r_inflight;

  logic           w_in_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_issue;
  logic [2:0]     w_ob_need;
  logic [1:0]     w_ob_occ;
  logic           w_ob_valid;
  logic [DW-1:0]  w_ob_data;

  // Handshake decode and RF strobes; reset and clear both suppress RF traffic.
  always_comb begin
    w_in_ready = (r_rf_cnt < NWD'(DEPTH)) & ~bus.i_clear;
    w_push     = bus.i_in_valid & w_in_ready & ~i_rst;
    w_pop      = w_ob_valid & bus.i_out_ready & ~bus.i_clear;
    // Buffer slots still committed after this cycle's pop; a read issues only into a free slot.
    w_ob_need  = 3'(w_ob_occ) + 3'(r_inflight) - 3'(w_pop);
    w_issue    = (r_rf_cnt != '0) & (w_ob_need < 3'(RF_OB_DEPTH)) & ~bus.i_clear & ~i_rst;

    bus.o_in_ready  = w_in_ready;
    bus.o_out_valid = w_ob_valid;
    bus.o_out_data  = w_ob_data;
    bus.o_count     = CWD'(r_rf_cnt) + CWD'(r_inflight) + CWD'(w_ob_occ);

    o_rf_write = w_push;
    o_rf_waddr = r_wptr;
    o_rf_wdata = w_push ? bus.i_in_data : '0;
    o_rf_read  = w_issue;
    o_rf_raddr = r_rptr;
  end

  // Pointer, RF occupancy and in-flight tracking; an entry leaves the RF count at issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rf_cnt   <= '0;
      r_inflight <= 1'b0;
    end else if (bus.i_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rf_cnt   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)  r_wptr <= AWD'(ptr_wrap(32'(r_wptr), DEPTH));
      if (w_issue) r_rptr <= AWD'(ptr_wrap(32'(r_rptr), DEPTH));
      r_rf_cnt   <= r_rf_cnt + NWD'(w_push) - NWD'(w_issue);
      r_inflight <= w_issue;
    end
  end

  // Read data lands in the buffer the cycle after issue; a clear that cycle drops it.
  rf_2p_fifo_ctrl_ob_buf #(
    .W (DW)
  ) u_ob (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (bus.i_clear),
    .i_push  (r_inflight),
    .i_data  (i_rf_rdata),
    .i_pop   (w_pop),
    .o_occ   (w_ob_occ),
    .o_valid (w_ob_valid),
    .o_data  (w_ob_data)
  );

  // Issue uses the registered count, so a read never targets the word being written.
  a_no_addr_hazard : assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_rf_read && o_rf_write && (o_rf_raddr == o_rf_waddr)));

endmodule
